adc_fifo_writer: RTL and testbench

Write-side counterpart to the USB-side ADC FIFO register reader. It runs in the ADC clock domain and packs captured ADC samples into the byte stream that the reader later pulls out. In 12-bit mode it packs two samples into three bytes; in low-res mode it writes one byte per sample, either the 8 MSBs or the 8 LSBs. It buffers bytes against FIFO backpressure, counts stream segments, and drives the sticky error byte that the reader reports.

---
 rtl/adc_fifo_writer_pkg.sv | 20 ++
 rtl/adc_byte_ring.sv | 52 +++++
 rtl/adc_fifo_writer.sv | 183 ++++++++++++++++++
 tb/tb_adc_fifo_writer.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/adc_fifo_writer_pkg.sv
// Shared constants and types for the ADC-side FIFO byte packer.
// Error bit positions, packer phase encoding and staging ring depth.
package adc_fifo_writer_pkg;

  localparam int ERR_OVERRUN = 0;
  localparam int ERR_FULL    = 1;
  localparam int ERR_ODD     = 2;

  localparam int RING_DEPTH  = 4;

  typedef enum logic {
    PH_A = 1'b0,
    PH_B = 1'b1
  } phase_t;

  function automatic logic [7:0] lowres_byte(input logic [11:0] sample, input logic use_lsb);
    return use_lsb ? sample[7:0] : sample[11:4];
  endfunction

endpackage

// File: rtl/adc_byte_ring.sv
// Four-entry byte staging ring: push one or two bytes, pop one per cycle.
// The caller guarantees room before pushing and a non-empty ring before popping.
module adc_byte_ring
  import adc_fifo_writer_pkg::*;
(
  input  logic       clk_adc,
  input  logic       reset_n,
  input  logic       push,
  input  logic       push_two,
  input  logic [7:0] push_byte0,
  input  logic [7:0] push_byte1,
  input  logic       pop,
  output logic [7:0] head,
  output logic [2:0] free_count,
  output logic       empty
);

  logic [7:0] mem [RING_DEPTH];
  logic [1:0] wr_ptr;
  logic [1:0] rd_ptr;
  logic [2:0] count;
  logic [2:0] push_n;
  logic [2:0] pop_n;

  always_comb begin
    push_n = 3'd0;
    if (push) push_n = push_two ? 3'd2 : 3'd1;
    pop_n = {2'b00, pop};
  end

  always_ff @(posedge clk_adc or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < RING_DEPTH; i++) mem[i] <= 8'h00;
      wr_ptr <= 2'd0;
      rd_ptr <= 2'd0;
      count  <= 3'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_byte0;
        if (push_two) mem[wr_ptr + 2'd1] <= push_byte1;
        wr_ptr <= wr_ptr + push_n[1:0];
      end
      if (pop) rd_ptr <= rd_ptr + 2'd1;
      count <= count + push_n - pop_n;
    end
  end

  assign head       = mem[rd_ptr];
  assign free_count = 3'(RING_DEPTH) - count;
  assign empty      = (count == 3'd0);

endmodule

// File: rtl/adc_fifo_writer.sv
// Packs ADC samples into the byte FIFO (12-bit 2-into-3 or one byte per sample).
// Define ADC_FIFO_WRITER_STATS_EN to build the saturating bytes_written counter.
module adc_fifo_writer
  import adc_fifo_writer_pkg::*;
#(
  parameter int pADC_BITS  = 12,
  parameter int pSEG_WIDTH = 17
) (
  input  logic                  clk_adc,
  input  logic                  reset_n,
  input  logic                  capture_go,
  input  logic [pADC_BITS-1:0]  adc_data,
  input  logic                  adc_valid,
  input  logic                  low_res,
  input  logic                  low_res_lsb,
  input  logic [pSEG_WIDTH-1:0] stream_segment_threshold,
  input  logic                  clear_fifo_errors,
  input  logic                  fifo_full,
  output logic                  fifo_wr_en,
  output logic [7:0]            fifo_wr_data,
  output logic [7:0]            fifo_error_stat,
  output logic                  segment_done,
  output logic [31:0]           bytes_written
);

  localparam logic [pSEG_WIDTH-1:0] SEG_ONE = pSEG_WIDTH'(1);

  logic                  active;
  logic                  lr_q;
  logic                  lsb_q;
  phase_t                phase;
  logic [3:0]            held_nibble;
  logic                  flush_pending;
  logic [pSEG_WIDTH-1:0] seg_cnt;
  logic [2:0]            err_q;

  logic       sample_seen;
  logic       room_ok;
  logic       accept;
  logic       drop;
  logic       stopping;
  logic       start;
  logic       flush_push;
  logic       ring_push;
  logic       ring_push_two;
  logic [7:0] ring_byte0;
  logic [7:0] ring_byte1;
  logic       ring_pop;
  logic [7:0] ring_head;
  logic [2:0] ring_free;
  logic       ring_empty;
  logic [2:0] new_err;

  adc_byte_ring u_ring (
    .clk_adc    (clk_adc),
    .reset_n    (reset_n),
    .push       (ring_push),
    .push_two   (ring_push_two),
    .push_byte0 (ring_byte0),
    .push_byte1 (ring_byte1),
    .pop        (ring_pop),
    .head       (ring_head),
    .free_count (ring_free),
    .empty      (ring_empty)
  );

  // In 12-bit mode every sample needs two free slots so the A/B pair never splits.
  always_comb begin
    sample_seen = active & capture_go & adc_valid;
    room_ok     = lr_q ? (ring_free >= 3'd1) : (ring_free >= 3'd2);
    accept      = sample_seen & room_ok;
    drop        = sample_seen & ~room_ok;
    stopping    = active & ~capture_go;
    start       = ~active & capture_go & ring_empty & ~flush_pending;
    flush_push  = flush_pending & (ring_free >= 3'd2);
    ring_pop    = ~ring_empty & ~fifo_full;

    ring_push     = 1'b0;
    ring_push_two = 1'b0;
    ring_byte0    = 8'h00;
    ring_byte1    = 8'h00;
    if (flush_push) begin
      ring_push     = 1'b1;
      ring_push_two = 1'b1;
      ring_byte0    = {held_nibble, 4'h0};
    end else if (accept) begin
      ring_push = 1'b1;
      if (lr_q) begin
        ring_byte0 = lowres_byte(adc_data[11:0], lsb_q);
      end else if (phase == PH_A) begin
        ring_byte0 = adc_data[11:4];
      end else begin
        ring_push_two = 1'b1;
        ring_byte0    = {held_nibble, adc_data[11:8]};
        ring_byte1    = adc_data[7:0];
      end
    end

    new_err              = 3'b000;
    new_err[ERR_OVERRUN] = drop;
    new_err[ERR_FULL]    = active & fifo_full;
    new_err[ERR_ODD]     = stopping & (phase == PH_B);
  end

  // Capture control: mode latch, A/B phase and the odd-sample flush request.
  always_ff @(posedge clk_adc or negedge reset_n) begin
    if (!reset_n) begin
      active        <= 1'b0;
      lr_q          <= 1'b0;
      lsb_q         <= 1'b0;
      phase         <= PH_A;
      held_nibble   <= 4'h0;
      flush_pending <= 1'b0;
    end else begin
      if (start) begin
        active <= 1'b1;
        lr_q   <= low_res;
        lsb_q  <= low_res_lsb;
        phase  <= PH_A;
      end else if (stopping) begin
        active <= 1'b0;
        phase  <= PH_A;
        if (phase == PH_B) flush_pending <= 1'b1;
      end else if (accept && !lr_q) begin
        if (phase == PH_A) begin
          held_nibble <= adc_data[3:0];
          phase       <= PH_B;
        end else begin
          phase <= PH_A;
        end
      end
      if (flush_push) flush_pending <= 1'b0;
    end
  end

  // Write strobe, segment tracking and sticky errors; set beats clear.
  always_ff @(posedge clk_adc or negedge reset_n) begin
    if (!reset_n) begin
      fifo_wr_en   <= 1'b0;
      fifo_wr_data <= 8'h00;
      segment_done <= 1'b0;
      seg_cnt      <= '0;
      err_q        <= 3'b000;
    end else begin
      fifo_wr_en   <= ring_pop;
      fifo_wr_data <= ring_pop ? ring_head : 8'h00;
      segment_done <= 1'b0;
      if (start) begin
        seg_cnt <= '0;
      end else if (ring_pop) begin
        if ((stream_segment_threshold != '0) &&
            ((seg_cnt + SEG_ONE) == stream_segment_threshold)) begin
          segment_done <= 1'b1;
          seg_cnt      <= '0;
        end else begin
          seg_cnt <= seg_cnt + SEG_ONE;
        end
      end
      err_q <= (clear_fifo_errors ? 3'b000 : err_q) | new_err;
    end
  end

  assign fifo_error_stat = {5'b00000, err_q};

`ifdef ADC_FIFO_WRITER_STATS_EN
  logic [31:0] byte_count;

  always_ff @(posedge clk_adc or negedge reset_n) begin
    if (!reset_n) begin
      byte_count <= 32'd0;
    end else if (start) begin
      byte_count <= 32'd0;
    end else if (ring_pop && (byte_count != 32'hFFFF_FFFF)) begin
      byte_count <= byte_count + 32'd1;
    end
  end

  assign bytes_written = byte_count;
`else
  assign bytes_written = 32'd0;
`endif

endmodule

// File: tb/tb_adc_fifo_writer.sv
// Self-checking bench for adc_fifo_writer: directed cases plus randomized captures
// compared against a bit-stream packing model.
module tb_adc_fifo_writer;

  logic        clk_adc = 1'b0;
  logic        reset_n = 1'b0;
  logic        capture_go = 1'b0;
  logic [11:0] adc_data = 12'h000;
  logic        adc_valid = 1'b0;
  logic        low_res = 1'b0;
  logic        low_res_lsb = 1'b0;
  logic [16:0] stream_segment_threshold = 17'd0;
  logic        clear_fifo_errors = 1'b0;
  logic        fifo_full = 1'b0;
  logic        fifo_wr_en;
  logic [7:0]  fifo_wr_data;
  logic [7:0]  fifo_error_stat;
  logic        segment_done;
  logic [31:0] bytes_written;

  adc_fifo_writer #(.pADC_BITS(12), .pSEG_WIDTH(17)) dut (
    .clk_adc                  (clk_adc),
    .reset_n                  (reset_n),
    .capture_go               (capture_go),
    .adc_data                 (adc_data),
    .adc_valid                (adc_valid),
    .low_res                  (low_res),
    .low_res_lsb              (low_res_lsb),
    .stream_segment_threshold (stream_segment_threshold),
    .clear_fifo_errors        (clear_fifo_errors),
    .fifo_full                (fifo_full),
    .fifo_wr_en               (fifo_wr_en),
    .fifo_wr_data             (fifo_wr_data),
    .fifo_error_stat          (fifo_error_stat),
    .segment_done             (segment_done),
    .bytes_written            (bytes_written)
  );

  always #5 clk_adc = ~clk_adc;

  int checks = 0;
  int errors = 0;
  logic [7:0]  got_q[$];
  logic [7:0]  exp_q[$];
  logic [11:0] samp_q[$];
  int          seg_at[$];
  int          wr_idx = 0;
  logic        full_at_edge = 1'b0;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  always @(posedge clk_adc) full_at_edge <= fifo_full;

  // Byte monitor: every write is captured, and must never target a full FIFO.
  always @(negedge clk_adc) begin
    if (reset_n) begin
      if (fifo_wr_en) begin
        got_q.push_back(fifo_wr_data);
        wr_idx++;
        checkOutput("wr_into_full", {31'd0, full_at_edge}, 32'd0);
        if (segment_done) seg_at.push_back(wr_idx);
      end
      if (segment_done) checkOutput("seg_with_wr", {31'd0, fifo_wr_en}, 32'd1);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk_adc);
    #1;
  endtask

  task automatic applyStimulus(input bit valid, input logic [11:0] data);
    adc_valid = valid;
    adc_data  = data;
    if (valid) samp_q.push_back(data);
    @(posedge clk_adc);
    #1;
    adc_valid = 1'b0;
  endtask

  // Reference: low-res is one chosen byte per sample; 12-bit is the sample
  // bit stream MSB-first, with an odd tail padded by twelve zero bits.
  task automatic modelBytes(input bit lr, input bit lsb);
    logic [23:0] pair;
    exp_q.delete();
    if (lr) begin
      foreach (samp_q[i]) exp_q.push_back(lsb ? samp_q[i][7:0] : samp_q[i][11:4]);
    end else begin
      for (int i = 0; i < samp_q.size(); i += 2) begin
        pair[23:12] = samp_q[i];
        pair[11:0]  = (i + 1 < samp_q.size()) ? samp_q[i + 1] : 12'h000;
        exp_q.push_back(pair[23:16]);
        exp_q.push_back(pair[15:8]);
        exp_q.push_back(pair[7:0]);
      end
    end
  endtask

  task automatic compareStream(input string tag);
    checkOutput({tag, "_count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      checkOutput($sformatf("%s_byte%0d", tag, i), {24'd0, got_q[i]}, {24'd0, exp_q[i]});
  endtask

  task automatic startCapture(input bit lr, input bit lsb);
    got_q.delete();
    seg_at.delete();
    samp_q.delete();
    wr_idx      = 0;
    low_res     = lr;
    low_res_lsb = lsb;
    capture_go  = 1'b1;
    tick(2);
    low_res     = ~lr;
    low_res_lsb = ~lsb;
  endtask

  task automatic stopCapture();
    capture_go = 1'b0;
    tick(20);
  endtask

  task automatic clearErrors();
    clear_fifo_errors = 1'b1;
    tick(1);
    clear_fifo_errors = 1'b0;
    tick(1);
  endtask

  function automatic logic [31:0] expBytes(input int n);
`ifdef ADC_FIFO_WRITER_STATS_EN
    return n;
`else
    return 32'd0;
`endif
  endfunction

  initial begin
    int snap;
    int n;
    int run;
    bit lr;
    bit lsb;

    reset_n = 1'b0;
    tick(3);
    checkOutput("rst_wr_en", {31'd0, fifo_wr_en}, 32'd0);
    checkOutput("rst_stat", {24'd0, fifo_error_stat}, 32'd0);
    checkOutput("rst_seg", {31'd0, segment_done}, 32'd0);
    checkOutput("rst_bytes", bytes_written, 32'd0);
    reset_n = 1'b1;
    tick(2);

    // 12-bit pair packs into three bytes
    startCapture(1'b0, 1'b0);
    applyStimulus(1'b1, 12'hABC);
    applyStimulus(1'b1, 12'h123);
    tick(6);
    checkOutput("pair_b0", {24'd0, got_q[0]}, 32'hAB);
    checkOutput("pair_b1", {24'd0, got_q[1]}, 32'hC1);
    checkOutput("pair_b2", {24'd0, got_q[2]}, 32'h23);
    checkOutput("pair_count", got_q.size(), 32'd3);
    checkOutput("pair_bytes_written", bytes_written, expBytes(3));
    stopCapture();
    checkOutput("pair_stat", {24'd0, fifo_error_stat}, 32'd0);

    // low-res byte selection
    startCapture(1'b1, 1'b1);
    applyStimulus(1'b1, 12'h5A7);
    stopCapture();
    modelBytes(1'b1, 1'b1);
    compareStream("lr_lsb");
    startCapture(1'b1, 1'b0);
    applyStimulus(1'b1, 12'h5A7);
    stopCapture();
    modelBytes(1'b1, 1'b0);
    compareStream("lr_msb");

    // backpressure: two samples fit, next two drop
    fifo_full = 1'b1;
    startCapture(1'b0, 1'b0);
    for (int i = 1; i <= 4; i++) applyStimulus(1'b1, 12'(i * 12'h111));
    tick(3);
    checkOutput("full_no_writes", got_q.size(), 32'd0);
    checkOutput("full_stat", {24'd0, fifo_error_stat}, 32'h03);
    fifo_full = 1'b0;
    tick(10);
    samp_q = samp_q[0:1];
    modelBytes(1'b0, 1'b0);
    compareStream("full_drain");
    stopCapture();
    clearErrors();
    checkOutput("full_cleared", {24'd0, fifo_error_stat}, 32'd0);

    // segment pulses
    stream_segment_threshold = 17'd3;
    startCapture(1'b1, 1'b0);
    for (int i = 0; i < 7; i++) applyStimulus(1'b1, 12'($urandom));
    stopCapture();
    checkOutput("seg_pulses", seg_at.size(), 32'd2);
    checkOutput("seg_first", seg_at[0], 32'd3);
    checkOutput("seg_second", seg_at[1], 32'd6);
    stream_segment_threshold = 17'd0;

    // odd sample count flush
    startCapture(1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 12'($urandom));
      tick(1);
    end
    stopCapture();
    modelBytes(1'b0, 1'b0);
    compareStream("odd");
    checkOutput("odd_b4", {24'd0, got_q[4]}, {24'd0, samp_q[2][3:0], 4'h0});
    checkOutput("odd_b5", {24'd0, got_q[5]}, 32'h00);
    checkOutput("odd_stat", {24'd0, fifo_error_stat}, 32'h04);
    checkOutput("odd_bytes_written", bytes_written, expBytes(6));
    clearErrors();
    checkOutput("odd_cleared", {24'd0, fifo_error_stat}, 32'd0);

    // reset mid-capture while a write is in flight
    fifo_full = 1'b1;
    startCapture(1'b1, 1'b0);
    applyStimulus(1'b1, 12'h3C5);
    applyStimulus(1'b1, 12'hA5A);
    fifo_full = 1'b0;
    @(posedge clk_adc);
    #3;
    reset_n    = 1'b0;
    capture_go = 1'b0;
    #1;
    checkOutput("rst_mid_wr_en", {31'd0, fifo_wr_en}, 32'd0);
    snap = got_q.size();
    tick(3);
    reset_n = 1'b1;
    tick(8);
    checkOutput("rst_mid_no_writes", got_q.size(), snap);
    checkOutput("rst_mid_stat", {24'd0, fifo_error_stat}, 32'd0);
    checkOutput("rst_mid_bytes", bytes_written, 32'd0);

    // randomized captures against the packing model
    for (int r = 0; r < 12; r++) begin
      lr  = 1'($urandom);
      lsb = 1'($urandom);
      n   = $urandom_range(1, 12);
      startCapture(lr, lsb);
      run = 0;
      for (int i = 0; i < n; i++) begin
        if ((!lr && run == 2) || $urandom_range(0, 3) == 0) begin
          applyStimulus(1'b0, 12'h000);
          run = 0;
        end
        applyStimulus(1'b1, 12'($urandom));
        run++;
      end
      stopCapture();
      modelBytes(lr, lsb);
      compareStream($sformatf("rnd%0d", r));
      checkOutput($sformatf("rnd%0d_stat", r), {24'd0, fifo_error_stat},
                  (!lr && (n % 2 == 1)) ? 32'h04 : 32'h00);
      checkOutput($sformatf("rnd%0d_bytes_written", r), bytes_written, expBytes(exp_q.size()));
      clearErrors();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
